// File: rtl/alu_pkg.sv
// Shared opcode and FSM-state definitions for the sequenced ALU.
package alu_pkg;

    localparam int ALU_OP_W = 4;

    // Codes 0-4 keep the legacy 3-bit encoding; 11-15 are unassigned.
    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9,
        ALU_MUL  = 4'd10
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } alu_state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, WIDTH cycles per product.
module alu_mul_iter #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] partial;

    // product is the accumulator after the current step, so on the final
    // step (done) the caller can register the full product directly.
    assign partial = mplier[0] ? mcand : '0;
    assign product = acc + partial;
    assign busy    = (cnt != '0);
    assign done    = (cnt == CW'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (start) begin
            acc    <= '0;
            mcand  <= a;
            mplier <= b;
            cnt    <= CW'(WIDTH);
        end else if (busy) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - CW'(1);
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle ops plus iterative MUL, registered result and flags.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             negative,
    output logic             carry,
    output logic             overflow,
    output logic             illegal,
    output logic [1:0]       dbg_state
);
    localparam int SHW = $clog2(WIDTH);

    alu_state_e       state_q, state_d;
    alu_op_e          op_e;
    logic             accept;
    logic             is_mul;
    logic             mul_busy;
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;
    logic [SHW-1:0]   shamt;
    logic [WIDTH:0]   add_ext;
    logic [WIDTH:0]   sub_ext;
    logic [WIDTH-1:0] comb_res;
    logic             comb_carry;
    logic             comb_ovf;
    logic             comb_ill;

    assign op_e      = alu_op_e'(op);
    assign is_mul    = (op_e == ALU_MUL);
    assign shamt     = b[SHW-1:0];
    assign add_ext   = {1'b0, a} + {1'b0, b};
    assign sub_ext   = {1'b0, a} - {1'b0, b};
    assign dbg_state = state_q;

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (accept && is_mul),
        .a       (a),
        .b       (b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    always_comb begin
        comb_res   = '0;
        comb_carry = 1'b0;
        comb_ovf   = 1'b0;
        comb_ill   = 1'b0;
        case (op_e)
            ALU_ADD: begin
                comb_res   = add_ext[WIDTH-1:0];
                comb_carry = add_ext[WIDTH];
                comb_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (add_ext[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SUB: begin
                // The extra bit of the widened subtract is the unsigned borrow.
                comb_res   = sub_ext[WIDTH-1:0];
                comb_carry = sub_ext[WIDTH];
                comb_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_ext[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_AND:  comb_res = a & b;
            ALU_OR:   comb_res = a | b;
            ALU_XOR:  comb_res = a ^ b;
            ALU_SLL:  comb_res = a << shamt;
            ALU_SRL:  comb_res = a >> shamt;
            ALU_SRA:  comb_res = $unsigned($signed(a) >>> shamt);
            ALU_SLT:  comb_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: comb_res = {{(WIDTH-1){1'b0}}, (a < b)};
            ALU_MUL:  comb_res = '0;
            default:  comb_ill = 1'b1;
        endcase
    end

    // Handshake: an op transfers on a rising edge where in_valid && in_ready;
    // a result transfers on a rising edge where out_valid && out_ready. in_ready
    // is combinational (state, out_ready) so DONE can hand off and accept at once.
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        case (state_q)
            IDLE:    in_ready = 1'b1;
            DONE:    in_ready = out_ready;
            default: in_ready = 1'b0;
        endcase
        if (rst) begin
            in_ready = 1'b0;
        end
        accept = in_valid && in_ready;
        case (state_q)
            IDLE: if (accept) state_d = is_mul ? MUL : DONE;
            MUL: begin
                if (mul_done) begin
                    state_d = DONE;
                end else if (!mul_busy) begin
                    state_d = IDLE;
                end
            end
            DONE: begin
                if (accept) begin
                    state_d = is_mul ? MUL : DONE;
                end else if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            negative  <= 1'b0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            state_q   <= state_d;
            out_valid <= (state_d == DONE);
            if (accept && !is_mul) begin
                result   <= comb_res;
                zero     <= (comb_res == '0);
                negative <= comb_res[WIDTH-1];
                carry    <= comb_carry;
                overflow <= comb_ovf;
                illegal  <= comb_ill;
            end else if (mul_done) begin
                result   <= mul_product;
                zero     <= (mul_product == '0);
                negative <= mul_product[WIDTH-1];
                carry    <= 1'b0;
                overflow <= 1'b0;
                illegal  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq with a scoreboard queue of expected result+flags.
module tb_alu_seq;
    localparam int W  = 64;
    localparam int CW = W + 5;
    typedef logic [CW-1:0] chk_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         zero, negative, carry, overflow, illegal;
    logic [1:0]   dbg_state;
    logic [4:0]   flags;

    int   passed = 0;
    int   total  = 0;
    int   cycle  = 0;
    chk_t exp_q[$];
    int   pop_cyc[$];

    assign flags = {zero, negative, carry, overflow, illegal};

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .negative  (negative),
        .carry     (carry),
        .overflow  (overflow),
        .illegal   (illegal),
        .dbg_state (dbg_state)
    );

    task automatic check(input string tag, input chk_t obs, input chk_t exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Reference: {result, zero, negative, carry, overflow, illegal}
    function automatic chk_t model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W:0]   e;
        logic [W-1:0] r;
        logic         c, v, il;
        c = 1'b0; v = 1'b0; il = 1'b0; r = '0; e = '0;
        case (o)
            4'd0: begin
                e = {1'b0, x} + {1'b0, y};
                r = e[W-1:0];
                c = e[W];
                v = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
            end
            4'd1: begin
                r = x - y;
                c = (x < y);
                v = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
            end
            4'd2:  r = x & y;
            4'd3:  r = x | y;
            4'd4:  r = x ^ y;
            4'd5:  r = x << y[5:0];
            4'd6:  r = x >> y[5:0];
            4'd7:  r = $unsigned($signed(x) >>> y[5:0]);
            4'd8:  r = ($signed(x) < $signed(y)) ? 64'd1 : 64'd0;
            4'd9:  r = (x < y) ? 64'd1 : 64'd0;
            4'd10: r = x * y;
            default: il = 1'b1;
        endcase
        return {r, (r == '0), r[W-1], c, v, il};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one op; returns 1ns after the accepting edge.
    task automatic send(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input bit expect_out);
        bit ok;
        int n;
        in_valid = 1'b1;
        op = o; a = x; b = y;
        ok = 1'b0;
        n  = 0;
        do begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 200);
        check("accept", chk_t'(ok), chk_t'(1));
        if (ok && expect_out) exp_q.push_back(model(o, x, y));
        in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", chk_t'(exp_q.size()), chk_t'(1));
            end else begin
                check("scoreboard", {result, flags}, exp_q.pop_front());
                pop_cyc.push_back(cycle);
            end
        end
    end

    initial begin
        int lat, bad, span;
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        op = 4'd0; a = '0; b = '0;

        repeat (2) begin
            @(negedge clk);
            check("rst_in_ready", chk_t'(in_ready), chk_t'(0));
            check("rst_out_valid", chk_t'(out_valid), chk_t'(0));
        end
        step();
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("reset_result", chk_t'(result), chk_t'(0));
        check("reset_flags", chk_t'(flags), chk_t'(0));
        check("reset_out_valid", chk_t'(out_valid), chk_t'(0));
        check("idle_in_ready", chk_t'(in_ready), chk_t'(1));
        step();

        send(4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
        check("add_latency", chk_t'(out_valid), chk_t'(1));
        check("add_res", chk_t'(result), chk_t'(64'h8000_0000_0000_0000));
        check("add_flags", chk_t'(flags), chk_t'(5'b01010));

        send(4'd1, 64'd5, 64'd5, 1'b1);
        check("sub_zero_res", chk_t'(result), chk_t'(0));
        check("sub_zero_flags", chk_t'(flags), chk_t'(5'b10000));
        send(4'd1, 64'd3, 64'd5, 1'b1);
        check("sub_borrow_res", chk_t'(result), chk_t'(64'hFFFF_FFFF_FFFF_FFFE));
        check("sub_borrow_flags", chk_t'(flags), chk_t'(5'b01100));

        send(4'd7, 64'h8000_0000_0000_0000, 64'h43, 1'b1);
        check("sra_res", chk_t'(result), chk_t'(64'hF000_0000_0000_0000));
        send(4'd8, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
        check("slt_res", chk_t'(result), chk_t'(1));
        send(4'd9, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
        check("sltu_res", chk_t'(result), chk_t'(0));
        step();

        out_ready = 1'b0;
        send(4'd10, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 1'b1);
        lat = 0; bad = 0;
        while (lat < 200) begin
            @(negedge clk);
            if (out_valid) break;
            if (in_ready) bad++;
            lat++;
        end
        check("mul_latency", chk_t'(lat), chk_t'(64));
        check("mul_in_ready_low", chk_t'(bad), chk_t'(0));
        check("mul_res", chk_t'(result), chk_t'(64'hFFFF_FFFE_0000_0001));
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (result !== 64'hFFFF_FFFE_0000_0001 || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
        end
        check("mul_hold_stable", chk_t'(bad), chk_t'(0));
        step();
        out_ready = 1'b1;
        step();
        check("mul_drained", chk_t'(exp_q.size()), chk_t'(0));

        send(4'd10, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
        repeat (20) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        bad = 0;
        repeat (80) begin
            @(negedge clk);
            if (out_valid) bad++;
        end
        check("rst_mid_mul_no_out", chk_t'(bad), chk_t'(0));
        check("rst_mid_mul_ready", chk_t'(in_ready), chk_t'(1));
        step();

        pop_cyc.delete();
        for (int i = 0; i < 10; i++) begin
            send(4'd0, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
        end
        repeat (3) step();
        check("tp_count", chk_t'(pop_cyc.size()), chk_t'(10));
        span = (pop_cyc.size() == 10) ? (pop_cyc[9] - pop_cyc[0]) : -1;
        check("tp_consecutive", chk_t'(span), chk_t'(9));

        send(4'd15, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
        check("illegal_res", chk_t'(result), chk_t'(0));
        check("illegal_flags", chk_t'(flags), chk_t'(5'b10001));

        for (int i = 0; i < 24; i++) begin
            logic [3:0]   o;
            logic [W-1:0] x, y;
            o = 4'($urandom_range(0, 15));
            x = {$urandom, $urandom};
            y = ($urandom_range(0, 1) == 1) ? {$urandom, $urandom} : W'($urandom_range(0, 80));
            send(o, x, y, 1'b1);
            repeat ($urandom_range(0, 2)) step();
        end

        lat = 0;
        while (exp_q.size() != 0 && lat < 300) begin
            step();
            lat++;
        end
        step();
        check("final_drain", chk_t'(exp_q.size()), chk_t'(0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
